ofdm_randomizer: RTL and testbench



---
 rtl/ofdm_pkg.sv | 20 ++
 rtl/prbs15_lfsr.sv | 26 ++
 rtl/ofdm_randomizer.sv | 45 ++++
 tb/tb_ofdm_randomizer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/ofdm_pkg.sv
// Shared constants and IV helper for the OFDM randomizer, MAC control and bench.
package ofdm_pkg;

    localparam int PRBS_LEN = 15;
    // Generator 1 + x^14 + x^15: stages 14 and 15 feed back.
    localparam int TAP_A = 14;
    localparam int TAP_B = 15;

    // Per-burst seed built from the 4 LSBs of BSID, UIUC and frame number.
    // Bit layout (b14..b0): bsid[3:0] | 1 1 | uiuc[3:0] | 1 | frame_num[3:0].
    // The fixed ones keep the seed nonzero for every field combination.
    function automatic logic [PRBS_LEN-1:0] gen_rand_iv(
        input logic [3:0] bsid,
        input logic [3:0] uiuc,
        input logic [3:0] frame_num
    );
        return {bsid, 2'b11, uiuc, 1'b1, frame_num};
    endfunction

endpackage

// File: rtl/prbs15_lfsr.sv
// 15-stage Fibonacci LFSR; bit_out is the feedback bit for the current state.
module prbs15_lfsr
    import ofdm_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                advance,
    input  logic                load,
    input  logic [PRBS_LEN-1:0] load_val,
    output logic                bit_out,
    output logic [PRBS_LEN-1:0] state
);

    assign bit_out = state[TAP_A-1] ^ state[TAP_B-1];

    // Reset clears, load seeds, advance shifts stage n into n+1 with feedback into stage 1.
    always_ff @(posedge clk) begin
        if (reset)
            state <= '0;
        else if (load)
            state <= load_val;
        else if (advance)
            state <= {state[PRBS_LEN-2:0], bit_out};
    end

endmodule

// File: rtl/ofdm_randomizer.sv
// Serial bit randomizer: XORs each accepted bit with the PRBS15 feedback bit, 1-cycle registered latency.
module ofdm_randomizer
    import ofdm_pkg::*;
(
    input  logic                reset,
    input  logic                clk,
    input  logic                in_bits,
    input  logic                in_valid,
    output logic                out_bits,
    output logic                out_valid,
    input  logic [PRBS_LEN-1:0] rand_iv,
    input  logic                reload
);

    logic                prbs_bit;
    logic [PRBS_LEN-1:0] prbs_state;
    logic                accept;

    // Data presented during a reload cycle is dropped and does not advance the sequence.
    assign accept = in_valid & ~reload;

    prbs15_lfsr u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .advance  (accept),
        .load     (reload),
        .load_val (rand_iv),
        .bit_out  (prbs_bit),
        .state    (prbs_state)
    );

    // Output register; out_bits holds its last value when nothing is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_bits  <= 1'b0;
            out_valid <= 1'b0;
        end else if (accept) begin
            out_bits  <= in_bits ^ prbs_bit;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ofdm_randomizer.sv
// Self-checking bench: PRBS reference is the recurrence x[n] = x[n-14] ^ x[n-15] over a bit history.
module tb_ofdm_randomizer;
    import ofdm_pkg::*;

    logic        reset    = 1'b1;
    logic        clk      = 1'b0;
    logic        in_bits  = 1'b0;
    logic        in_valid = 1'b0;
    logic        reload   = 1'b0;
    logic [14:0] rand_iv  = '0;
    logic        out_bits;
    logic        out_valid;

    int n_assert = 0;
    int n_fail   = 0;

    // hist[0] is the oldest of the last 15 sequence bits, hist[14] the newest (stage 1).
    bit   hist[$];
    logic m_out = 1'b0;
    logic [15:0] seq;

    ofdm_randomizer dut (
        .reset     (reset),
        .clk       (clk),
        .in_bits   (in_bits),
        .in_valid  (in_valid),
        .out_bits  (out_bits),
        .out_valid (out_valid),
        .rand_iv   (rand_iv),
        .reload    (reload)
    );

    always #5 clk = ~clk;

    task automatic model_load(input logic [14:0] iv);
        hist.delete();
        for (int k = 14; k >= 0; k--) hist.push_back(iv[k]);
    endtask

    function automatic bit model_next();
        bit f;
        f = hist[0] ^ hist[1];
        hist.push_back(f);
        void'(hist.pop_front());
        return f;
    endfunction

    function automatic logic [14:0] model_vect();
        logic [14:0] v;
        for (int k = 0; k < 15; k++) v[k] = hist[14-k];
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step_bit(input bit b, input bit v);
        logic exp_v;
        in_bits  = b;
        in_valid = v;
        reload   = 1'b0;
        @(posedge clk);
        #1;
        exp_v = v;
        if (v) m_out = b ^ model_next();
        check("out_valid", 32'(out_valid), 32'(exp_v));
        check("out_bits", 32'(out_bits), 32'(m_out));
    endtask

    task automatic do_reload(input logic [14:0] iv, input bit inv);
        rand_iv  = iv;
        reload   = 1'b1;
        in_valid = inv;
        in_bits  = 1'($urandom);
        @(posedge clk);
        #1;
        model_load(iv);
        check("reload_valid", 32'(out_valid), 32'd0);
        check("reload_bits_hold", 32'(out_bits), 32'(m_out));
        check("reload_vect", 32'(dut.u_lfsr.state), 32'(model_vect()));
        reload   = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input bit inv);
        reset    = 1'b1;
        in_valid = inv;
        in_bits  = 1'b1;
        @(posedge clk);
        #1;
        model_load('0);
        m_out = 1'b0;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_bits", 32'(out_bits), 32'd0);
        check("reset_vect", 32'(dut.u_lfsr.state), 32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [14:0] seed, before_gap;
        int          first_ret;
        int          k;

        // Reset, then all-zero state passes data straight through.
        do_reset(1'b0);
        step_bit(1, 1); step_bit(0, 1); step_bit(1, 1); step_bit(1, 1);
        step_bit(0, 0);

        // Single-tap seed: 1, thirteen 0s, 1, 1; state ends at 15'h0003.
        do_reload(15'h4000, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step_bit(0, 1);
            seq[i] = out_bits;
        end
        check("single_tap_seq", 32'(seq), 32'h0000_C001);
        check("single_tap_vect", 32'(dut.u_lfsr.state), 32'h0003);

        // Same seed with a 3-cycle valid gap after bit 5.
        do_reload(15'h4000, 1'b0);
        k = 0;
        for (int i = 0; i < 5; i++) begin step_bit(0, 1); seq[k] = out_bits; k++; end
        before_gap = dut.u_lfsr.state;
        for (int i = 0; i < 3; i++) step_bit(1'($urandom), 0);
        check("gap_vect_hold", 32'(dut.u_lfsr.state), 32'(before_gap));
        for (int i = 0; i < 11; i++) begin step_bit(0, 1); seq[k] = out_bits; k++; end
        check("gap_seq", 32'(seq), 32'h0000_C001);

        // Reload mid-stream with in_valid high: no output that cycle, sequence restarts.
        for (int i = 0; i < 10; i++) step_bit(1'($urandom), 1);
        do_reload(15'h4000, 1'b1);
        for (int i = 0; i < 16; i++) begin step_bit(0, 1); seq[i] = out_bits; end
        check("midstream_seq", 32'(seq), 32'h0000_C001);

        // Burst seeded from gen_rand_iv with random data and random gaps.
        for (int b = 0; b < 3; b++) begin
            do_reload(gen_rand_iv(4'($urandom), 4'($urandom), 4'($urandom)), 1'b0);
            for (int i = 0; i < 64; i++) step_bit(1'($urandom), ($urandom_range(0, 3) != 0));
            check("burst_vect", 32'(dut.u_lfsr.state), 32'(model_vect()));
        end

        // Reset mid-burst discards the in-flight bit.
        step_bit(1, 1);
        do_reset(1'b1);
        step_bit(1, 1); step_bit(0, 1);

        // Period: nonzero seed returns after exactly 32767 accepted bits.
        seed = 15'($urandom_range(1, 32767));
        do_reload(seed, 1'b0);
        first_ret = 0;
        for (int i = 0; i < 32767; i++) begin
            step_bit(0, 1);
            if (first_ret == 0 && dut.u_lfsr.state == seed) first_ret = i + 1;
        end
        check("period_len", 32'(first_ret), 32'd32767);
        check("period_vect", 32'(dut.u_lfsr.state), 32'(seed));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
